// File: rtl/join_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : join_counter_pkg
//  Description : Shared types and constants for the join counter: table
//                entry layout, index extraction and regIn field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package join_counter_pkg;

    // Closures are 64-byte aligned, so the index starts above the offset bits.
    localparam int c_IDX_LSB = 6;
    localparam int c_CNT_W   = 8;
    localparam int c_ADDR_W  = 64;

    // regIn_TDATA layout: {count, addr}
    localparam int c_REG_ADDR_LSB = 0;
    localparam int c_REG_CNT_LSB  = c_ADDR_W;

    // One direct-mapped slot: the full address is kept as the tag.
    typedef struct packed {
        logic                valid;
        logic [c_ADDR_W-1:0] tag;
        logic [c_CNT_W-1:0]  cnt;
    } entry_t;

    // Slot index of a closure address; caller casts to its index width.
    function automatic logic [31:0] idxOf(input logic [c_ADDR_W-1:0] addr,
                                          input int unsigned         lsb,
                                          input int unsigned         idxW);
        logic [c_ADDR_W-1:0] w_shifted;
        logic [c_ADDR_W-1:0] w_mask;
        w_shifted = addr >> lsb;
        w_mask    = (64'd1 << idxW) - 64'd1;
        return 32'(w_shifted & w_mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/join_ready_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : join_ready_fifo
//  Description : Two-deep register FIFO for completed closure addresses.
//                Head data is taken straight from a register, so it stays
//                stable while the consumer stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module join_ready_fifo #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_pushData,
    input  logic              i_push,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wrPtr;
    logic              r_rdPtr;
    logic [1:0]        r_count;

    logic              w_doPush;
    logic              w_doPop;

    assign o_full   = (r_count == 2'd2);
    assign o_empty  = (r_count == 2'd0);
    assign o_data   = r_mem[r_rdPtr];
    // A push into a full FIFO is ignored; the caller gates on o_full.
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop  && !o_empty;

    // Storage write: data needs no reset, occupancy tracking guards reads.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= ~r_wrPtr;
            end
            if (w_doPop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, w_doPush} - {1'b0, w_doPop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/join_counter.sv
`default_nettype none
// ============================================================================
//  Module      : join_counter
//  Description : Direct-mapped table of join counters. Registrations load a
//                slot; argument beats decrement it; a closure address is
//                emitted on readyOut once its count reaches zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module join_counter
    import join_counter_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_LSB = c_IDX_LSB,
    parameter int CNT_W   = c_CNT_W
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic [c_ADDR_W+CNT_W-1:0] regIn_TDATA,
    input  logic                      regIn_TVALID,
    output logic                      regIn_TREADY,
    input  logic [c_ADDR_W-1:0]       argIn_TDATA,
    input  logic                      argIn_TVALID,
    output logic                      argIn_TREADY,
    output logic [c_ADDR_W-1:0]       readyOut_TDATA,
    output logic                      readyOut_TVALID,
    input  logic                      readyOut_TREADY,
    output logic                      err_miss,
    output logic                      err_underflow
);

    localparam int IDX_W = $clog2(ENTRIES);

    // The entry struct carries a fixed-width counter field.
    if (CNT_W != c_CNT_W) begin : g_cntWidthCheck
        $error("join_counter: CNT_W must equal c_CNT_W");
    end
    if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_entriesCheck
        $error("join_counter: ENTRIES must be a power of two >= 2");
    end

    entry_t              r_table [ENTRIES];
    logic                r_errMiss;

    logic [c_ADDR_W-1:0] w_regAddr;
    logic [CNT_W-1:0]    w_regCnt;
    logic [IDX_W-1:0]    w_regIdx;
    logic                w_regCntZero;
    logic                w_regFire;
    logic                w_regWrite;

    logic [IDX_W-1:0]    w_argIdx;
    entry_t              w_argEntry;
    logic                w_argFire;
    logic                w_argHit;
    logic                w_argDone;

    logic                w_fifoFull;
    logic                w_fifoEmpty;
    logic                w_push;
    logic [c_ADDR_W-1:0] w_pushData;
    logic                w_pop;

    assign w_regAddr    = regIn_TDATA[c_REG_ADDR_LSB +: c_ADDR_W];
    assign w_regCnt     = regIn_TDATA[c_REG_CNT_LSB +: CNT_W];
    assign w_regIdx     = IDX_W'(idxOf(w_regAddr, IDX_LSB, IDX_W));
    assign w_regCntZero = (w_regCnt == '0);

    assign w_argIdx     = IDX_W'(idxOf(argIn_TDATA, IDX_LSB, IDX_W));
    assign w_argEntry   = r_table[w_argIdx];

    // A zero-count registration bypasses the table, so a busy slot does not
    // block it. Registration has priority; arg only proceeds when reg idles
    // or is blocked on a busy slot, which guarantees forward progress.
    assign regIn_TREADY = !ap_rst && !w_fifoFull &&
                          (!r_table[w_regIdx].valid || w_regCntZero);
    assign w_regFire    = regIn_TVALID && regIn_TREADY;
    assign w_regWrite   = w_regFire && !w_regCntZero;

    assign argIn_TREADY = !ap_rst && !w_fifoFull && !w_regFire;
    assign w_argFire    = argIn_TVALID && argIn_TREADY;
    assign w_argHit     = w_argEntry.valid && (w_argEntry.tag == argIn_TDATA);
    // Entries are only written with cnt >= 1, so this never wraps.
    assign w_argDone    = w_argHit && (w_argEntry.cnt <= CNT_W'(1));

    assign w_push       = (w_regFire && w_regCntZero) || (w_argFire && w_argDone);
    assign w_pushData   = w_regFire ? w_regAddr : argIn_TDATA;

    assign readyOut_TVALID = !w_fifoEmpty && !ap_rst;
    assign w_pop           = readyOut_TVALID && readyOut_TREADY;

    assign err_miss      = r_errMiss;
    assign err_underflow = 1'b0;

    // Table read-modify-write: at most one of register / decrement per cycle.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_regWrite) begin
            r_table[w_regIdx] <= '{valid: 1'b1, tag: w_regAddr, cnt: w_regCnt};
        end else if (w_argFire && w_argHit) begin
            if (w_argDone) begin
                r_table[w_argIdx].valid <= 1'b0;
            end else begin
                r_table[w_argIdx].cnt <= w_argEntry.cnt - CNT_W'(1);
            end
        end
    end

    // Sticky flag for argument beats that matched no live entry.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_errMiss <= 1'b0;
        end else if (w_argFire && !w_argHit) begin
            r_errMiss <= 1'b1;
        end
    end

    join_ready_fifo #(
        .DATA_W (c_ADDR_W)
    ) u_readyFifo (
        .clk        (ap_clk),
        .rst        (ap_rst),
        .i_pushData (w_pushData),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .o_data     (readyOut_TDATA),
        .o_full     (w_fifoFull),
        .o_empty    (w_fifoEmpty)
    );

endmodule
`default_nettype wire

// File: tb/tb_join_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_join_counter
//  Description : Self-checking bench for join_counter: directed scenarios
//                followed by randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_join_counter;

    localparam int ENTRIES = 16;
    localparam int CNT_W   = 8;
    localparam int IDX_LSB = 6;

    logic                ap_clk = 1'b0;
    logic                ap_rst;
    logic [64+CNT_W-1:0] regIn_TDATA;
    logic                regIn_TVALID;
    logic                regIn_TREADY;
    logic [63:0]         argIn_TDATA;
    logic                argIn_TVALID;
    logic                argIn_TREADY;
    logic [63:0]         readyOut_TDATA;
    logic                readyOut_TVALID;
    logic                readyOut_TREADY;
    logic                err_miss;
    logic                err_underflow;

    always #5 ap_clk = ~ap_clk;

    join_counter #(
        .ENTRIES (ENTRIES),
        .IDX_LSB (IDX_LSB),
        .CNT_W   (CNT_W)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .regIn_TDATA     (regIn_TDATA),
        .regIn_TVALID    (regIn_TVALID),
        .regIn_TREADY    (regIn_TREADY),
        .argIn_TDATA     (argIn_TDATA),
        .argIn_TVALID    (argIn_TVALID),
        .argIn_TREADY    (argIn_TREADY),
        .readyOut_TDATA  (readyOut_TDATA),
        .readyOut_TVALID (readyOut_TVALID),
        .readyOut_TREADY (readyOut_TREADY),
        .err_miss        (err_miss),
        .err_underflow   (err_underflow)
    );

    // Behavioural model: pending joins keyed by slot, outputs as a queue.
    longint unsigned mAddr [int];
    int              mRem  [int];
    longint unsigned mOut  [$];
    bit              mErr;

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkVal(input string tag, input logic [63:0] act,
                            input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int slotOf(input longint unsigned a);
        return int'((a / 64) % ENTRIES);
    endfunction

    // One clock: drive inputs, check outputs at the falling edge, then
    // advance the model by what the handshakes should have done.
    task automatic step(input bit rv, input longint unsigned raddr, input int rcnt,
                        input bit av, input longint unsigned aaddr,
                        input bit ordy, input bit rst);
        bit space, expRR, expAR, expOV, rFire, aFire, pop;
        int rs, as;
        regIn_TVALID    = rv;
        regIn_TDATA     = {CNT_W'(rcnt), raddr};
        argIn_TVALID    = av;
        argIn_TDATA     = aaddr;
        readyOut_TREADY = ordy;
        ap_rst          = rst;
        @(negedge ap_clk);
        space = (mOut.size() < 2);
        rs    = slotOf(raddr);
        as    = slotOf(aaddr);
        expRR = !rst && space && (!mAddr.exists(rs) || rcnt == 0);
        rFire = rv && expRR;
        expAR = !rst && space && !rFire;
        aFire = av && expAR;
        expOV = !rst && (mOut.size() > 0);
        pop   = expOV && ordy;
        checkVal("regIn_TREADY", 64'(regIn_TREADY), 64'(expRR));
        checkVal("argIn_TREADY", 64'(argIn_TREADY), 64'(expAR));
        checkVal("readyOut_TVALID", 64'(readyOut_TVALID), 64'(expOV));
        if (expOV) checkVal("readyOut_TDATA", readyOut_TDATA, mOut[0]);
        checkVal("err_miss", 64'(err_miss), 64'(mErr));
        checkVal("err_underflow", 64'(err_underflow), 64'd0);
        @(posedge ap_clk);
        #1;
        if (rst) begin
            mAddr.delete();
            mRem.delete();
            mOut.delete();
            mErr = 1'b0;
        end else begin
            if (pop) void'(mOut.pop_front());
            if (rFire) begin
                if (rcnt == 0) begin
                    mOut.push_back(raddr);
                end else begin
                    mAddr[rs] = raddr;
                    mRem[rs]  = rcnt;
                end
            end
            if (aFire) begin
                if (mAddr.exists(as) && mAddr[as] == aaddr) begin
                    mRem[as] = mRem[as] - 1;
                    if (mRem[as] == 0) begin
                        mAddr.delete(as);
                        mRem.delete(as);
                        mOut.push_back(aaddr);
                    end
                end else begin
                    mErr = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 0, 0, 0, ordy, 0);
    endtask

    initial begin
        longint unsigned ra, aa;
        ap_rst          = 1'b1;
        regIn_TVALID    = 1'b0;
        regIn_TDATA     = '0;
        argIn_TVALID    = 1'b0;
        argIn_TDATA     = '0;
        readyOut_TREADY = 1'b1;
        mErr            = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        step(0, 0, 0, 1, 64'h40, 1, 1);           // reset state
        idle(1);

        // Two-child join completes on the second argument.
        step(1, 64'h1000, 2, 0, 0, 1, 0);
        step(0, 0, 0, 1, 64'h1000, 1, 0);
        step(0, 0, 0, 1, 64'h1000, 1, 0);
        idle(1); idle(1);

        // Zero-count registration bypasses the table; later arg misses.
        step(1, 64'h2040, 0, 0, 0, 1, 0);
        idle(1);
        step(0, 0, 0, 1, 64'h2040, 1, 0);
        idle(1);

        // Slot collision blocks registration until the join completes.
        step(1, 64'h1000, 1, 0, 0, 1, 0);
        step(1, 64'h1400, 1, 0, 0, 1, 0);
        step(1, 64'h1400, 1, 1, 64'h1000, 1, 0);
        step(1, 64'h1400, 1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 64'h1400, 1, 0);
        idle(1); idle(1);

        // Back-pressure: two outputs queue, third arg stalls, then drain.
        step(1, 64'h3000, 1, 0, 0, 0, 0);
        step(1, 64'h3040, 1, 0, 0, 0, 0);
        step(1, 64'h3080, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 64'h3000, 0, 0);
        step(0, 0, 0, 1, 64'h3040, 0, 0);
        step(0, 0, 0, 1, 64'h3080, 0, 0);
        step(0, 0, 0, 1, 64'h3080, 1, 0);
        step(0, 0, 0, 1, 64'h3080, 1, 0);
        idle(1); idle(1); idle(1);

        // Arbitration: reg wins when its slot is free, arg wins when busy.
        step(1, 64'h6000, 1, 0, 0, 1, 0);
        step(1, 64'h60C0, 1, 1, 64'h6000, 1, 0);
        step(0, 0, 0, 1, 64'h6000, 1, 0);
        step(1, 64'h6100, 1, 0, 0, 1, 0);
        step(1, 64'h6500, 1, 1, 64'h60C0, 1, 0);
        step(0, 0, 0, 1, 64'h6100, 1, 0);
        step(1, 64'h6500, 1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 64'h6500, 1, 0);
        idle(1); idle(1);

        // Reset mid-operation discards pending joins and queued output.
        step(1, 64'h7000, 2, 0, 0, 0, 0);
        step(1, 64'h7040, 2, 0, 0, 0, 0);
        step(1, 64'h7080, 0, 0, 0, 0, 0);
        idle(0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(1);
        step(0, 0, 0, 1, 64'h7000, 1, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 1);

        // Randomized traffic over a few slots and tags to force collisions.
        for (int n = 0; n < 3000; n++) begin
            ra = (longint'($urandom_range(0, 1)) << 63) |
                 (longint'($urandom_range(0, 2)) << 10) |
                 (longint'($urandom_range(0, 3)) << 6);
            aa = (longint'($urandom_range(0, 1)) << 63) |
                 (longint'($urandom_range(0, 2)) << 10) |
                 (longint'($urandom_range(0, 3)) << 6);
            step($urandom_range(0, 1) == 1, ra, int'($urandom_range(0, 3)),
                 $urandom_range(0, 2) != 0, aa,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
